// File: rtl/add_sub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package add_sub_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operation select encoding.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Digit counter width: ceil(log2(n)), at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_sub_digit.sv
// Combinational DIGIT-bit ripple adder slice. c_msb is the carry into the
// top bit, needed to derive signed overflow on the most significant digit.
module add_sub_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic w_carry;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    w_carry = cin;
    s       = '0;
    c_msb   = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ w_carry;
      if (i == DIGIT - 1) begin
        c_msb = w_carry;
      end
      w_carry = (x[i] & y[i]) | (w_carry & (x[i] ^ y[i]));
    end
    cout = w_carry;
  end

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// A WIDTH-bit operand pair is processed DIGIT bits per cycle, LSB digit first.
// Optional feature macro: SATURATE_EN (signed saturation of sum on overflow).
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             v,
  output logic             busy
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = cnt_width(N);

  state_e             r_state;
  state_e             w_state_next;

  // r_a doubles as the result register: result digits enter at the MSB end
  // while operand digits leave at the LSB end.
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_v;

  logic [DIGIT-1:0]   w_s;
  logic               w_dcout;
  logic               w_c_msb;
  logic               w_v;
  logic               w_last;
  logic               w_accept;
  logic               w_sub;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;
  logic [WIDTH-1:0]   w_final_sum;

  assign w_sub    = (op == OP_SUB);
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == CNT_W'(N - 1));
  assign w_v      = w_c_msb ^ w_dcout;

  add_sub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x    (r_a[DIGIT-1:0]),
    .y    (r_b[DIGIT-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_dcout),
    .c_msb(w_c_msb)
  );

  // Next contents of the shift registers; a single digit needs no shifting.
  if (N == 1) begin : g_single
    assign w_a_shift = w_s;
    assign w_b_shift = '0;
  end else begin : g_multi
    assign w_a_shift = {w_s, r_a[WIDTH-1:DIGIT]};
    assign w_b_shift = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
  end

`ifdef SATURATE_EN
  logic r_a_sign;

  // Sign of operand a, which picks the saturation direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sign <= 1'b0;
    end else if (w_accept) begin
      r_a_sign <= a[WIDTH-1];
    end
  end

  // Clamp the completed result on signed overflow.
  always_comb begin
    w_final_sum = w_a_shift;
    if (w_v) begin
      w_final_sum = r_a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_final_sum = w_a_shift;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand load, per-digit shift/carry update and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      if (w_accept) begin
        // Subtraction as a + ~b + 1: invert b, seed carry with 1.
        r_a     <= a;
        r_b     <= b ^ {WIDTH{w_sub}};
        r_carry <= w_sub;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= w_a_shift;
        r_b     <= w_b_shift;
        r_carry <= w_dcout;
        if (w_last) begin
          r_sum  <= w_final_sum;
          r_cout <= w_dcout;
          r_v    <= w_v;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sum  = r_sum;
  assign Cout = r_cout;
  assign v    = r_v;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: one instance with DIGIT=2 (N=4), one with DIGIT=8 (N=1).
// Honours SATURATE_EN when defined.
module tb_add_sub_serial;
  import add_sub_pkg::*;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

`ifdef SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      in_valid = '0;
  logic [1:0]      in_ready;
  logic [1:0][7:0] a = '0;
  logic [1:0][7:0] b = '0;
  logic [1:0]      op = '0;
  logic [1:0]      out_valid;
  logic [1:0]      out_ready = '0;
  logic [1:0][7:0] sum;
  logic [1:0]      cout;
  logic [1:0]      v;
  logic [1:0]      busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_sub_serial #(.WIDTH(8), .DIGIT(2)) u_dut_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .op(op[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .Cout(cout[0]), .v(v[0]), .busy(busy[0])
  );

  add_sub_serial #(.WIDTH(8), .DIGIT(8)) u_dut_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .op(op[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1]), .Cout(cout[1]), .v(v[1]), .busy(busy[1])
  );

  function automatic int n_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Reference result from signed/unsigned integer arithmetic.
  function automatic res_t ref_calc(input logic [7:0] x, input logic [7:0] y, input logic o);
    res_t res;
    int   sx, sy, r, ux, uy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    r  = (o == OP_SUB) ? sx - sy : sx + sy;
    res.v = (r > 127) || (r < -128);
    res.s = r[7:0];
    res.c = (o == OP_SUB) ? (ux >= uy) : (ux + uy > 255);
    if (SAT && res.v) res.s = (r > 127) ? 8'h7F : 8'h80;
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 computing, 2 result held.
  int   m_phase[2] = '{0, 0};
  int   m_left[2]  = '{0, 0};
  res_t m_pend[2]  = '{'0, '0};
  res_t m_res[2]   = '{'0, '0};

  for (genvar g = 0; g < 2; g++) begin : g_model
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_phase[g] <= 0;
        m_left[g]  <= 0;
        m_res[g]   <= '0;
      end else begin
        case (m_phase[g])
          0: if (in_valid[g]) begin
            m_pend[g]  <= ref_calc(a[g], b[g], op[g]);
            m_left[g]  <= n_of(g);
            m_phase[g] <= 1;
          end
          1: begin
            m_left[g] <= m_left[g] - 1;
            if (m_left[g] == 1) begin
              m_phase[g] <= 2;
              m_res[g]   <= m_pend[g];
            end
          end
          default: if (out_ready[g]) m_phase[g] <= 0;
        endcase
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(m_phase[k] == 0));
      chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_phase[k] != 0));
      chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_phase[k] == 2));
      chk($sformatf("sum[%0d]", k), 32'(sum[k]), 32'(m_res[k].s));
      chk($sformatf("cout[%0d]", k), 32'(cout[k]), 32'(m_res[k].c));
      chk($sformatf("v[%0d]", k), 32'(v[k]), 32'(m_res[k].v));
    end
  end

  // Present operands at a falling edge; the next rising edge accepts them.
  task automatic op_start(input int k, input logic [7:0] x, input logic [7:0] y, input logic o);
    @(negedge clk);
    in_valid[k] = 1'b1;
    a[k]        = x;
    b[k]        = y;
    op[k]       = o;
    @(posedge clk);
  endtask

  // Called just after the accept edge; checks latency and literal results.
  task automatic op_wait(input int k, input logic [7:0] es, input logic ec, input logic ev,
                         input string name);
    int lat = 0;
    @(negedge clk);
    in_valid[k] = 1'b0;
    while (!out_valid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(n_of(k)));
    chk({name, " sum"}, 32'(sum[k]), 32'(es));
    chk({name, " cout"}, 32'(cout[k]), 32'(ec));
    chk({name, " v"}, 32'(v[k]), 32'(ev));
    chk({name, " model"}, 32'(m_res[k]), 32'({es, ec, ev}));
  endtask

  task automatic op_release(input int k, input string name);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk({name, " in_ready after take"}, 32'(in_ready[k]), 32'd1);
    chk({name, " out_valid after take"}, 32'(out_valid[k]), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h01, 8'h03, OP_ADD, 8'h04, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, OP_ADD, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'h01, OP_SUB, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1};
    vecs[3] = '{8'h05, 8'h03, OP_SUB, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{8'h08, 8'h09, OP_SUB, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, OP_ADD, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1};

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset in_ready[%0d]", k), 32'(in_ready[k]), 32'd1);
      chk($sformatf("reset out_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("reset busy[%0d]", k), 32'(busy[k]), 32'd0);
      chk($sformatf("reset sum[%0d]", k), 32'(sum[k]), 32'd0);
      chk($sformatf("reset cout[%0d]", k), 32'(cout[k]), 32'd0);
      chk($sformatf("reset v[%0d]", k), 32'(v[k]), 32'd0);
    end
    #2 rst = 1'b0;

    // Directed vectors on both digit widths.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 7; i++) begin
        string nm;
        nm = $sformatf("n%0d vec%0d", n_of(k), i);
        op_start(k, vecs[i].a, vecs[i].b, vecs[i].op);
        op_wait(k, vecs[i].s, vecs[i].c, vecs[i].v, nm);
        op_release(k, nm);
      end
    end

    // Backpressure with a competing request held on the inputs.
    op_start(0, 8'h05, 8'h03, OP_SUB);
    op_wait(0, 8'h02, 1'b1, 1'b0, "bp first");
    in_valid[0] = 1'b1;
    a[0]        = 8'h10;
    b[0]        = 8'h20;
    op[0]       = OP_ADD;
    repeat (3) @(negedge clk);
    chk("bp held sum", 32'(sum[0]), 32'h02);
    chk("bp held cout", 32'(cout[0]), 32'd1);
    chk("bp held v", 32'(v[0]), 32'd0);
    chk("bp in_ready", 32'(in_ready[0]), 32'd0);
    chk("bp out_valid", 32'(out_valid[0]), 32'd1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("bp in_ready after take", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    op_wait(0, 8'h30, 1'b0, 1'b0, "bp second");
    op_release(0, "bp second");

    // Reset during the second RUN cycle aborts the operation.
    op_start(0, 8'h55, 8'h22, OP_ADD);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort out_valid", 32'(out_valid[0]), 32'd0);
    chk("abort in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort busy", 32'(busy[0]), 32'd0);
    chk("abort sum", 32'(sum[0]), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    op_start(0, 8'h0F, 8'h01, OP_ADD);
    op_wait(0, 8'h10, 1'b0, 1'b0, "after abort");
    op_release(0, "after abort");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
